// File: rtl/test_waveform_gen_if.sv
// rtl/test_waveform_gen_if.sv - configuration, enable and sample bundle for test_waveform_gen
interface test_waveform_gen_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  enable;
  logic                  cfg_load;
  logic [1:0]            cfg_mode;
  logic [DATA_WIDTH-1:0] cfg_step;
  logic [DATA_WIDTH-1:0] cfg_min;
  logic [DATA_WIDTH-1:0] cfg_max;
  logic [DATA_WIDTH-1:0] wave;
  logic                  peak;
  logic                  period_done;
  logic                  cfg_error;

  modport master (
    output enable, cfg_load, cfg_mode, cfg_step, cfg_min, cfg_max,
    input  wave, peak, period_done, cfg_error
  );

  modport slave (
    input  enable, cfg_load, cfg_mode, cfg_step, cfg_min, cfg_max,
    output wave, peak, period_done, cfg_error
  );
endinterface

// File: rtl/test_waveform_gen.sv
// rtl/test_waveform_gen.sv - bounded triangle/sawtooth/square test waveform generator
module test_waveform_gen #(
  parameter int         DATA_WIDTH = 12,
  parameter logic [1:0] RESET_MODE = 2'd0
) (
  input logic                 ref_clk,
  input logic                 rst,
  test_waveform_gen_if.slave  bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    MODE_TRI    = 2'd0,
    MODE_SAW_UP = 2'd1,
    MODE_SAW_DN = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e          mode_q;
  logic [W-1:0]   step_q, min_q, max_q;
  logic           err_q;
  logic [W-1:0]   wave_q, wave_d;
  logic [W-1:0]   hold_q, hold_d;
  dir_e           dir_q, dir_d;
  logic           peak_q, peak_d;
  logic           pd_q, pd_d;

  logic [W-1:0]   step_eff;
  logic [W:0]     up_sum;
  logic [W:0]     dn_lim;
  logic [W:0]     hold_inc;

  // Extra top bit keeps ramp sums and limits from wrapping through 0 or all-ones.
  assign step_eff = (step_q == '0) ? W'(1) : step_q;
  assign up_sum   = {1'b0, wave_q} + {1'b0, step_eff};
  assign dn_lim   = {1'b0, min_q} + {1'b0, step_eff};
  assign hold_inc = {1'b0, hold_q} + (W+1)'(1);

  always_comb begin
    wave_d = wave_q;
    dir_d  = dir_q;
    hold_d = hold_q;
    peak_d = 1'b0;
    pd_d   = 1'b0;
    if (err_q) begin
      wave_d = min_q;
    end else if (bus.enable) begin
      case (mode_q)
        MODE_TRI: begin
          if (dir_q == DIR_UP) begin
            if (up_sum >= {1'b0, max_q}) begin
              wave_d = max_q;
              dir_d  = DIR_DOWN;
              peak_d = 1'b1;
            end else begin
              wave_d = up_sum[W-1:0];
            end
          end else begin
            if ({1'b0, wave_q} <= dn_lim) begin
              wave_d = min_q;
              dir_d  = DIR_UP;
              pd_d   = 1'b1;
            end else begin
              wave_d = wave_q - step_eff;
            end
          end
        end
        MODE_SAW_UP: begin
          if (wave_q == max_q) begin
            wave_d = min_q;
            pd_d   = 1'b1;
          end else if (up_sum >= {1'b0, max_q}) begin
            wave_d = max_q;
            peak_d = 1'b1;
          end else begin
            wave_d = up_sum[W-1:0];
          end
        end
        MODE_SAW_DN: begin
          if (wave_q == min_q) begin
            wave_d = max_q;
            peak_d = 1'b1;
            pd_d   = 1'b1;
          end else if ({1'b0, wave_q} <= dn_lim) begin
            wave_d = min_q;
          end else begin
            wave_d = wave_q - step_eff;
          end
        end
        MODE_SQUARE: begin
          // hold_q counts enabled cycles already spent at the current level
          if (hold_inc >= {1'b0, step_eff}) begin
            hold_d = '0;
            if (wave_q == max_q) begin
              wave_d = min_q;
              pd_d   = 1'b1;
            end else begin
              wave_d = max_q;
              peak_d = 1'b1;
            end
          end else begin
            hold_d = hold_inc[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      mode_q <= mode_e'(RESET_MODE);
      step_q <= W'(1);
      min_q  <= '0;
      max_q  <= '1;
      err_q  <= 1'b0;
      wave_q <= '0;
      dir_q  <= DIR_UP;
      hold_q <= '0;
      peak_q <= 1'b0;
      pd_q   <= 1'b0;
    end else if (bus.cfg_load) begin
      mode_q <= mode_e'(bus.cfg_mode);
      step_q <= bus.cfg_step;
      min_q  <= bus.cfg_min;
      max_q  <= bus.cfg_max;
      err_q  <= (bus.cfg_min >= bus.cfg_max);
      wave_q <= bus.cfg_min;
      dir_q  <= DIR_UP;
      hold_q <= '0;
      peak_q <= 1'b0;
      pd_q   <= 1'b0;
    end else begin
      wave_q <= wave_d;
      dir_q  <= dir_d;
      hold_q <= hold_d;
      peak_q <= peak_d;
      pd_q   <= pd_d;
    end
  end

  assign bus.wave        = wave_q;
  assign bus.peak        = peak_q;
  assign bus.period_done = pd_q;
  assign bus.cfg_error   = err_q;
endmodule

// File: tb/tb_test_waveform_gen.sv
// tb/tb_test_waveform_gen.sv - self-checking bench for test_waveform_gen
module tb_test_waveform_gen;
  localparam int W = 12;
  localparam int MAXV = (1 << W) - 1;

  logic ref_clk = 1'b0;
  logic rst;
  always #5 ref_clk = ~ref_clk;

  test_waveform_gen_if #(.DATA_WIDTH(W)) bus ();

  test_waveform_gen #(.DATA_WIDTH(W), .RESET_MODE(2'd0)) dut (
    .ref_clk (ref_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // reference state, plain integers
  int m_mode, m_step, m_min, m_max, m_wave, m_hold;
  bit m_up, m_err, m_peak, m_pd;

  task automatic model_reset();
    m_mode = 0; m_step = 1; m_min = 0; m_max = MAXV; m_err = 0;
    m_wave = 0; m_up = 1; m_hold = 0; m_peak = 0; m_pd = 0;
  endtask

  task automatic model_edge(input bit ld, input bit en, input int md, input int st,
                            input int mn, input int mx);
    int s;
    m_peak = 0;
    m_pd   = 0;
    if (ld) begin
      m_mode = md; m_step = st; m_min = mn; m_max = mx;
      m_err = (mn >= mx); m_wave = mn; m_up = 1; m_hold = 0;
      return;
    end
    if (m_err) begin
      m_wave = m_min;
      return;
    end
    if (!en) return;
    s = (m_step == 0) ? 1 : m_step;
    case (m_mode)
      0: begin
        if (m_up) begin
          if (m_wave + s >= m_max) begin m_wave = m_max; m_up = 0; m_peak = 1; end
          else m_wave = m_wave + s;
        end else begin
          if (m_wave - s <= m_min) begin m_wave = m_min; m_up = 1; m_pd = 1; end
          else m_wave = m_wave - s;
        end
      end
      1: begin
        if (m_wave == m_max) begin m_wave = m_min; m_pd = 1; end
        else begin
          m_wave = (m_wave + s < m_max) ? m_wave + s : m_max;
          m_peak = (m_wave == m_max);
        end
      end
      2: begin
        if (m_wave == m_min) begin m_wave = m_max; m_peak = 1; m_pd = 1; end
        else m_wave = (m_wave - s > m_min) ? m_wave - s : m_min;
      end
      default: begin
        m_hold = m_hold + 1;
        if (m_hold >= s) begin
          m_hold = 0;
          if (m_wave == m_max) begin m_wave = m_min; m_pd = 1; end
          else begin m_wave = m_max; m_peak = 1; end
        end
      end
    endcase
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic drive(input bit ld, input bit en, input int md, input int st,
                       input int mn, input int mx);
    bus.cfg_load = ld;
    bus.enable   = en;
    if (ld) begin
      bus.cfg_mode = 2'(md);
      bus.cfg_step = W'(st);
      bus.cfg_min  = W'(mn);
      bus.cfg_max  = W'(mx);
    end
    @(posedge ref_clk);
    #1;
    model_edge(ld, en, md, st, mn, mx);
    bus.cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0; bus.cfg_load = 1'b0; bus.cfg_mode = 2'd0;
    bus.cfg_step = '0; bus.cfg_min = '0; bus.cfg_max = '0;
    #2;
    n_cmp++;
    if (bus.wave !== 12'd0 || bus.peak !== 1'b0 || bus.period_done !== 1'b0 || bus.cfg_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got wave=%0d pk=%b pd=%b err=%b exp 0/0/0/0",
               bus.wave, bus.peak, bus.period_done, bus.cfg_error);
    end
    @(posedge ref_clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive(0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (bus.wave !== 12'd1) begin
      n_fail++; $display("FAIL first_step got %0d exp 1", bus.wave);
    end
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.wave !== 12'd2 || bus.peak !== 1'b0) begin
      n_fail++; $display("FAIL freeze got wave=%0d pk=%b exp 2/0", bus.wave, bus.peak);
    end
  endtask

  task automatic test_triangle_full();
    int pk_cnt = 0, pd_cnt = 0, pk_at = -1, pd_at = -1, bad = 0;
    drive(1, 1, 0, 1, 0, MAXV);
    n_cmp++;
    if (bus.wave !== 12'd0 || bus.cfg_error !== 1'b0) begin
      n_fail++; $display("FAIL tri_load got wave=%0d err=%b exp 0/0", bus.wave, bus.cfg_error);
    end
    for (int i = 1; i <= 2 * MAXV; i++) begin
      int exp_w;
      drive(0, 1, 0, 0, 0, 0);
      exp_w = (i <= MAXV) ? i : 2 * MAXV - i;
      if (bus.wave !== W'(exp_w) && bad < 4) begin
        bad++;
        $display("FAIL tri_full_wave cyc %0d got %0d exp %0d", i, bus.wave, exp_w);
      end
      if (bus.peak === 1'b1) begin pk_cnt++; pk_at = i; end
      if (bus.period_done === 1'b1) begin pd_cnt++; pd_at = i; end
    end
    n_cmp++;
    if (bad != 0) n_fail++;
    n_cmp++;
    if (pk_cnt != 1 || pk_at != MAXV) begin
      n_fail++; $display("FAIL tri_full_peak got cnt=%0d at=%0d exp 1 at %0d", pk_cnt, pk_at, MAXV);
    end
    n_cmp++;
    if (pd_cnt != 1 || pd_at != 2 * MAXV) begin
      n_fail++; $display("FAIL tri_full_period got cnt=%0d at=%0d exp 1 at %0d", pd_cnt, pd_at, 2 * MAXV);
    end
  endtask

  task automatic test_triangle_small();
    int exp_w[8] = '{10, 14, 18, 20, 16, 12, 10, 14};
    bit exp_pk[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    bit exp_pd[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    drive(1, 1, 0, 4, 10, 20);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) drive(0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (bus.wave !== W'(exp_w[i]) || bus.peak !== exp_pk[i] || bus.period_done !== exp_pd[i]) begin
        n_fail++;
        $display("FAIL tri_small[%0d] got %0d/%b/%b exp %0d/%b/%b", i, bus.wave, bus.peak,
                 bus.period_done, exp_w[i], exp_pk[i], exp_pd[i]);
      end
    end
  endtask

  task automatic test_sawtooth();
    int exp_w[6] = '{0, 3, 6, 7, 0, 3};
    bit exp_pk[6] = '{0, 0, 0, 1, 0, 0};
    bit exp_pd[6] = '{0, 0, 0, 0, 1, 0};
    drive(1, 0, 1, 3, 0, 7);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) drive(0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (bus.wave !== W'(exp_w[i]) || bus.peak !== exp_pk[i] || bus.period_done !== exp_pd[i]) begin
        n_fail++;
        $display("FAIL saw_up[%0d] got %0d/%b/%b exp %0d/%b/%b", i, bus.wave, bus.peak,
                 bus.period_done, exp_w[i], exp_pk[i], exp_pd[i]);
      end
    end
  endtask

  task automatic test_square();
    bit en_seq[9] = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
    int exp_w[9]  = '{100, 100, 200, 200, 200, 200, 200, 100, 100};
    bit exp_pk[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    bit exp_pd[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    drive(1, 1, 3, 3, 100, 200);
    n_cmp++;
    if (bus.wave !== 12'd100) begin
      n_fail++; $display("FAIL square_load got %0d exp 100", bus.wave);
    end
    for (int i = 0; i < 9; i++) begin
      drive(0, en_seq[i], 0, 0, 0, 0);
      n_cmp++;
      if (bus.wave !== W'(exp_w[i]) || bus.peak !== exp_pk[i] || bus.period_done !== exp_pd[i]) begin
        n_fail++;
        $display("FAIL square[%0d] got %0d/%b/%b exp %0d/%b/%b", i, bus.wave, bus.peak,
                 bus.period_done, exp_w[i], exp_pk[i], exp_pd[i]);
      end
    end
  endtask

  task automatic test_cfg_error();
    int exp_w[3] = '{54, 58, 60};
    drive(1, 1, 0, 4, 50, 50);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.cfg_error !== 1'b1 || bus.wave !== 12'd50 || bus.peak !== 1'b0 || bus.period_done !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_err_hold[%0d] got err=%b wave=%0d pk=%b pd=%b exp 1/50/0/0", i,
                 bus.cfg_error, bus.wave, bus.peak, bus.period_done);
      end
      drive(0, 1, 0, 0, 0, 0);
    end
    drive(1, 1, 0, 4, 50, 60);
    n_cmp++;
    if (bus.cfg_error !== 1'b0 || bus.wave !== 12'd50) begin
      n_fail++; $display("FAIL cfg_err_clear got err=%b wave=%0d exp 0/50", bus.cfg_error, bus.wave);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (bus.wave !== W'(exp_w[i])) begin
        n_fail++; $display("FAIL cfg_err_restart[%0d] got %0d exp %0d", i, bus.wave, exp_w[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 0, 500, 0, 3000);
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (bus.wave !== 12'd2000) begin
      n_fail++; $display("FAIL pre_reset_wave got %0d exp 2000", bus.wave);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.wave !== 12'd0 || bus.peak !== 1'b0 || bus.period_done !== 1'b0 || bus.cfg_error !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got wave=%0d pk=%b pd=%b err=%b exp 0/0/0/0",
               bus.wave, bus.peak, bus.period_done, bus.cfg_error);
    end
    @(posedge ref_clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (bus.wave !== 12'd2) begin
      n_fail++; $display("FAIL resume_up got %0d exp 2", bus.wave);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 10; c++) begin
      int md, st, mn, mx;
      md = $urandom_range(0, 3);
      st = $urandom_range(0, 40);
      mn = $urandom_range(0, MAXV);
      if ($urandom_range(0, 7) == 0) mx = $urandom_range(0, mn);
      else mx = (mn + $urandom_range(1, 300) > MAXV) ? MAXV : mn + $urandom_range(1, 300);
      drive(1, $urandom_range(0, 1) == 1, md, st, mn, mx);
      for (int i = 0; i < 300; i++) begin
        n_cmp++;
        if (bus.wave !== W'(m_wave) || bus.peak !== m_peak || bus.period_done !== m_pd ||
            bus.cfg_error !== m_err) begin
          n_fail++;
          if (bad < 6)
            $display("FAIL random cfg %0d cyc %0d got %0d/%b/%b/%b exp %0d/%b/%b/%b", c, i,
                     bus.wave, bus.peak, bus.period_done, bus.cfg_error, m_wave, m_peak, m_pd, m_err);
          bad++;
        end
        drive(0, $urandom_range(0, 3) != 0, 0, 0, 0, 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_triangle_full();
    test_triangle_small();
    test_sawtooth();
    test_square();
    test_cfg_error();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
